channel_combiner: RTL and testbench

CHANNEL_COMBINER -- requirements
Module: channel_combiner

---
 rtl/gps_synth_pkg.sv | 25 ++
 rtl/combiner_lane.sv | 78 +++++++
 rtl/channel_combiner.sv | 104 ++++++++++
 tb/tb_channel_combiner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gps_synth_pkg.sv
// Shared constants and helpers for the GPS signal synthesiser datapath.
package gps_synth_pkg;

    localparam int NCO_W  = 6;
    localparam int GAIN_W = 4;
    localparam int PROD_W = 11;

    // Clamp a signed value into the range of a w-bit signed number.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] res;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            res = hi;
        end else if (v < lo) begin
            res = lo;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/combiner_lane.sv
// One datapath lane: code-signed gain multiply, channel accumulate, shift and saturate.
module combiner_lane
    import gps_synth_pkg::*;
#(
    parameter int ACC_W     = 15,
    parameter int OUT_SHIFT = 2,
    parameter int OUT_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_in,
    input  logic signed [NCO_W-1:0]  x_in,
    input  logic                     code_in,
    input  logic        [GAIN_W-1:0] gain_in,
    input  logic                     acc_en,
    input  logic                     fin_in,
    output logic signed [OUT_W-1:0]  y_out,
    output logic                     sat_out
);

    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic signed [OUT_W-1:0]  y_d, y_q;
    logic signed [PROD_W-1:0] x_ext_s, x_neg_s, gain_ext_s;
    logic signed [ACC_W-1:0]  sum_s, shifted_s;
    logic signed [31:0]       wide_s, sat_val_s;
    logic                     clamp_s;

    // Product, accumulator and output next-state; widening happens before negation so -32 becomes +32.
    always_comb begin
        x_ext_s    = $signed({{(PROD_W-NCO_W){x_in[NCO_W-1]}}, x_in});
        x_neg_s    = code_in ? -x_ext_s : x_ext_s;
        gain_ext_s = $signed({{(PROD_W-GAIN_W){1'b0}}, gain_in});
        prod_d     = prod_q;
        if (load_in) begin
            prod_d = x_neg_s * gain_ext_s;
        end else begin
            prod_d = prod_q;
        end

        sum_s     = acc_q + $signed({{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q});
        shifted_s = sum_s >>> OUT_SHIFT;
        wide_s    = $signed({{(32-ACC_W){shifted_s[ACC_W-1]}}, shifted_s});
        sat_val_s = saturate(wide_s, OUT_W);
        clamp_s   = (sat_val_s != wide_s);

        acc_d   = acc_q;
        y_d     = y_q;
        sat_out = 1'b0;
        if (acc_en) begin
            if (fin_in) begin
                acc_d   = '0;
                y_d     = sat_val_s[OUT_W-1:0];
                sat_out = clamp_s;
            end else begin
                acc_d = sum_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            acc_q  <= '0;
            y_q    <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            y_q    <= y_d;
        end
    end

    assign y_out = y_q;

endmodule

// File: rtl/channel_combiner.sv
// Sums per-channel NCO samples into one I/Q output sample per period, with sticky status flags.
module channel_combiner
    import gps_synth_pkg::*;
#(
    parameter int NUM_CH    = 16,
    parameter int OUT_SHIFT = 2,
    parameter int OUT_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     dv_in,
    input  logic                     last_in,
    input  logic signed [NCO_W-1:0]  real_in,
    input  logic signed [NCO_W-1:0]  imag_in,
    input  logic                     code_in,
    input  logic        [GAIN_W-1:0] gain_in,
    input  logic                     clear_in,
    output logic                     dv_out,
    output logic signed [OUT_W-1:0]  real_out,
    output logic signed [OUT_W-1:0]  imag_out,
    output logic                     sat_flag,
    output logic                     ch_err
);

    localparam int ACC_W = $clog2(NUM_CH) + PROD_W;
    localparam int CNT_W = $clog2(NUM_CH) + 1;

    logic             p_valid_d, p_valid_q;
    logic             p_last_d, p_last_q;
    logic             dv_out_d, dv_out_q;
    logic [CNT_W-1:0] ch_cnt_d, ch_cnt_q;
    logic             sat_d, sat_q;
    logic             err_d, err_q;
    logic             sat_i_s, sat_q_lane_s, err_set_s;

    combiner_lane #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)) u_lane_i (
        .clk(clk), .reset_n(reset_n), .load_in(dv_in), .x_in(real_in),
        .code_in(code_in), .gain_in(gain_in), .acc_en(p_valid_q), .fin_in(p_last_q),
        .y_out(real_out), .sat_out(sat_i_s)
    );

    combiner_lane #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)) u_lane_q (
        .clk(clk), .reset_n(reset_n), .load_in(dv_in), .x_in(imag_in),
        .code_in(code_in), .gain_in(gain_in), .acc_en(p_valid_q), .fin_in(p_last_q),
        .y_out(imag_out), .sat_out(sat_q_lane_s)
    );

    // Valid pipeline, channel counting and sticky flags; a set beats a same-cycle clear.
    always_comb begin
        p_valid_d = dv_in;
        p_last_d  = dv_in & last_in;
        dv_out_d  = p_valid_q & p_last_q;
        err_set_s = p_valid_q & ~p_last_q & ((ch_cnt_q + CNT_W'(1)) == CNT_W'(NUM_CH));

        ch_cnt_d = ch_cnt_q;
        if (p_valid_q) begin
            if (p_last_q) begin
                ch_cnt_d = '0;
            end else begin
                ch_cnt_d = ch_cnt_q + CNT_W'(1);
            end
        end else begin
            ch_cnt_d = ch_cnt_q;
        end

        sat_d = clear_in ? 1'b0 : sat_q;
        if (sat_i_s || sat_q_lane_s) begin
            sat_d = 1'b1;
        end else begin
            sat_d = sat_d;
        end

        err_d = clear_in ? 1'b0 : err_q;
        if (err_set_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            dv_out_q  <= 1'b0;
            ch_cnt_q  <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
            dv_out_q  <= dv_out_d;
            ch_cnt_q  <= ch_cnt_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
        end
    end

    assign dv_out   = dv_out_q;
    assign sat_flag = sat_q;
    assign ch_err   = err_q;

endmodule

// File: tb/tb_channel_combiner.sv
// Directed self-checking bench for channel_combiner with hand-computed expectations.
module tb_channel_combiner;

    logic              clk;
    logic              reset_n;
    logic              dv_in;
    logic              last_in;
    logic signed [5:0] real_in;
    logic signed [5:0] imag_in;
    logic              code_in;
    logic [3:0]        gain_in;
    logic              clear_in;
    logic              dv_out;
    logic signed [7:0] real_out;
    logic signed [7:0] imag_out;
    logic              sat_flag;
    logic              ch_err;

    int tests_run;
    int tests_failed;

    channel_combiner #(.NUM_CH(16), .OUT_SHIFT(2), .OUT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .dv_in(dv_in), .last_in(last_in),
        .real_in(real_in), .imag_in(imag_in), .code_in(code_in), .gain_in(gain_in),
        .clear_in(clear_in), .dv_out(dv_out), .real_out(real_out), .imag_out(imag_out),
        .sat_flag(sat_flag), .ch_err(ch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        tests_run = tests_run + 1;
        if (obs != exp_v) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int im, input logic code, input int gain, input logic last);
        dv_in   = 1'b1;
        last_in = last;
        real_in = 6'(re);
        imag_in = 6'(im);
        code_in = code;
        gain_in = 4'(gain);
        tick();
    endtask

    task automatic drop();
        dv_in   = 1'b0;
        last_in = 1'b0;
    endtask

    initial begin
        int pulses;
        int prev_c;
        tests_run    = 0;
        tests_failed = 0;
        reset_n  = 1'b0;
        dv_in    = 1'b0;
        last_in  = 1'b0;
        real_in  = 6'sd0;
        imag_in  = 6'sd0;
        code_in  = 1'b0;
        gain_in  = 4'd0;
        clear_in = 1'b0;
        tick();
        tick();
        check_val("rst_dv", int'(dv_out), 0);
        check_val("rst_real", int'(real_out), 0);
        check_val("rst_imag", int'(imag_out), 0);
        check_val("rst_flags", int'({sat_flag, ch_err}), 0);
        reset_n = 1'b1;
        tick();

        // Single channel, -32 negated gives +32 -> 8; imag -5 -> floor(-1.25) = -2
        send(-32, 5, 1'b1, 1, 1'b1);
        drop();
        check_val("single_lat_early", int'(dv_out), 0);
        tick();
        check_val("single_dv", int'(dv_out), 1);
        check_val("single_real", int'(real_out), 8);
        check_val("single_imag_floor", int'(imag_out), -2);
        tick();
        check_val("single_dv_pulse", int'(dv_out), 0);
        check_val("single_hold", int'(real_out), 8);

        // last_in without dv_in is ignored
        last_in = 1'b1;
        tick();
        last_in = 1'b0;
        tick();
        tick();
        check_val("stray_last_dv", int'(dv_out), 0);
        check_val("stray_last_hold", int'(real_out), 8);

        // Two channels: 30 - 20 = 10 -> 2
        send(10, 3, 1'b0, 3, 1'b0);
        send(-20, 1, 1'b0, 1, 1'b1);
        drop();
        tick();
        check_val("two_dv", int'(dv_out), 1);
        check_val("two_real", int'(real_out), 2);
        check_val("two_imag", int'(imag_out), 2);
        check_val("two_sat", int'(sat_flag), 0);

        // Saturation with clear_in landing in the set cycle: set wins
        send(31, -32, 1'b0, 15, 1'b0);
        send(31, -32, 1'b0, 15, 1'b1);
        drop();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check_val("sat_dv", int'(dv_out), 1);
        check_val("sat_real", int'(real_out), 127);
        check_val("sat_imag", int'(imag_out), -128);
        check_val("sat_set_wins", int'(sat_flag), 1);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check_val("sat_cleared", int'(sat_flag), 0);

        // Channel-count overflow: 16 non-last strobes then a last one
        for (int i = 0; i < 15; i++) send(1, 0, 1'b0, 1, 1'b0);
        drop();
        tick();
        tick();
        check_val("err_15", int'(ch_err), 0);
        send(1, 0, 1'b0, 1, 1'b0);
        drop();
        tick();
        check_val("err_16", int'(ch_err), 1);
        send(4, 0, 1'b0, 1, 1'b1);
        drop();
        tick();
        check_val("err_dv", int'(dv_out), 1);
        check_val("err_real", int'(real_out), 5);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check_val("err_cleared", int'(ch_err), 0);

        // Reset in the middle of a period discards the partial sum
        for (int i = 0; i < 3; i++) send(10, 10, 1'b0, 5, 1'b0);
        drop();
        reset_n = 1'b0;
        tick();
        tick();
        check_val("midrst_dv", int'(dv_out), 0);
        check_val("midrst_real", int'(real_out), 0);
        reset_n = 1'b1;
        send(4, 0, 1'b0, 4, 1'b1);
        drop();
        tick();
        check_val("midrst_after_dv", int'(dv_out), 1);
        check_val("midrst_after_real", int'(real_out), 4);
        tick();

        // Throughput: continuous strobes, last every 4th; each period sums 1+2+3+4=10 -> 2
        pulses = 0;
        prev_c = 0;
        for (int c = 0; c < 36; c++) begin
            if (c < 32) begin
                dv_in   = 1'b1;
                last_in = ((c % 4) == 3);
                real_in = 6'((c % 4) + 1);
                imag_in = -6'((c % 4) + 1);
                code_in = 1'b0;
                gain_in = 4'd1;
            end else begin
                drop();
            end
            tick();
            if (dv_out) begin
                pulses = pulses + 1;
                check_val("tput_gap", c - prev_c, 4);
                check_val("tput_real", int'(real_out), 2);
                check_val("tput_imag", int'(imag_out), -3);
                prev_c = c;
            end
        end
        check_val("tput_pulses", pulses, 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
